// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: main + skid slot, registered ready,
// flush-to-bubble on the control field and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_main_clr;
  logic w_skid_ld_in;
  logic w_skid_clr;

  // Ready/valid come straight from the state flop, never from out_ready.
  assign w_in_ready  = (r_state != S_FULL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) w_next = S_ONE;
        end
        S_ONE: begin
          if (w_in_fire && !w_out_fire) w_next = S_FULL;
          else if (!w_in_fire && w_out_fire) w_next = S_EMPTY;
        end
        S_FULL: begin
          if (w_out_fire) w_next = S_ONE;
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_clr     = 1'b0;
    w_skid_ld_in   = 1'b0;
    w_skid_clr     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_main_ld_in = w_in_fire;
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) w_main_ld_in = 1'b1;
        else if (w_in_fire) w_skid_ld_in = 1'b1;
        else if (w_out_fire) w_main_clr = 1'b1;
      end
      S_FULL: begin
        w_main_ld_skid = w_out_fire;
        w_skid_clr     = w_out_fire;
      end
      default: begin
        w_main_clr = 1'b1;
        w_skid_clr = 1'b1;
      end
    endcase
  end

  // Flush only kills control bits; data is left in place.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_main_ld_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_main_ld_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_main_clr) begin
        r_main_ctrl <= '0;
      end
      if (w_skid_ld_in) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end else if (w_skid_clr) begin
        r_skid_ctrl <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (in_valid && !w_in_ready && !flush && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign level     = r_state;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed beats, queue of
// expected outputs popped by an independent monitor.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  level;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic [7:0]  s_out_ctrl;
  logic [1:0]  s_level;
  logic [3:0]  s_stall_cnt;

  int n_tests;
  int n_fail;
  logic [23:0] sb[$];

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .level(level), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .level(s_level), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // One clock: decide acceptance mid-cycle, update scoreboard at the edge.
  task automatic cyc();
    logic acc;
    logic kill;
    @(negedge clk);
    acc  = in_valid && in_ready && !flush && reset;
    kill = flush || !reset;
    @(posedge clk);
    if (kill) sb.delete();
    else if (acc) sb.push_back({in_data, in_ctrl});
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic [7:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: act=%0h req=none",
                 {out_data, out_ctrl});
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({out_data, out_ctrl} !== e) begin
          n_fail++;
          $display("FAIL sb_beat: act=%0h req=%0h",
                   {out_data, out_ctrl}, e);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    flush = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 16'h1234, 8'hFF);
    cyc();
    cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);

    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 16'h0, 8'h0);
    cyc();
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_ready", 32'(in_ready), 32'd1);

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i), 8'h81);
      cyc();
      if (i == 1) begin
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'd1);
        chk("lat_ctrl", 32'(out_ctrl), 32'h81);
      end
      chk("stream_lvl_le1", 32'(level <= 2'd1), 32'd1);
    end
    drive(1'b0, 16'h0, 8'h0);
    cyc();
    cyc();
    chk("stream_level", 32'(level), 32'd0);
    chk("stream_cnt", 32'(stall_cnt), 32'd0);
    chk("stream_sb", 32'(sb.size()), 32'd0);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 8'h11);
    cyc();
    drive(1'b1, 16'hBBBB, 8'h22);
    cyc();
    drive(1'b1, 16'hCCCC, 8'h33);
    cyc();
    cyc();
    cyc();
    chk("bp_level", 32'(level), 32'd2);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_cnt", 32'(stall_cnt), 32'd3);
    chk("bp_head", 32'(out_data), 32'hAAAA);
    out_ready = 1'b1;
    cyc();
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_cnt4", 32'(stall_cnt), 32'd4);
    cyc();
    drive(1'b0, 16'h0, 8'h0);
    cyc();
    chk("bp_drain_level", 32'(level), 32'd0);
    chk("bp_sb", 32'(sb.size()), 32'd0);

    // flush while full
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 8'hFF);
    cyc();
    drive(1'b1, 16'h2222, 8'hFF);
    cyc();
    chk("fl_full", 32'(level), 32'd2);
    flush = 1'b1;
    drive(1'b1, 16'hDDDD, 8'hFF);
    cyc();
    flush = 1'b0;
    drive(1'b0, 16'h0, 8'h0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ctrl", 32'(out_ctrl), 32'd0);
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_data_hold", 32'(out_data), 32'h1111);
    chk("fl_cnt", 32'(stall_cnt), 32'd4);
    out_ready = 1'b1;
    cyc();
    cyc();

    // flush in ONE with a ready input beat
    out_ready = 1'b0;
    drive(1'b1, 16'h3333, 8'h0F);
    cyc();
    flush = 1'b1;
    drive(1'b1, 16'hDDDD, 8'hFF);
    cyc();
    flush = 1'b0;
    drive(1'b0, 16'h0, 8'h0);
    chk("fl1_level", 32'(level), 32'd0);
    chk("fl1_ctrl", 32'(out_ctrl), 32'd0);
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("fl1_idle", 32'(level), 32'd0);

    // flush with concurrent out_fire: beat 0x4444 still consumed
    out_ready = 1'b0;
    drive(1'b1, 16'h4444, 8'h22);
    cyc();
    drive(1'b0, 16'h0, 8'h0);
    out_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flo_level", 32'(level), 32'd0);
    chk("flo_sb", 32'(sb.size()), 32'd0);

    // flush and reset together
    out_ready = 1'b0;
    drive(1'b1, 16'h5555, 8'h44);
    cyc();
    drive(1'b0, 16'h0, 8'h0);
    chk("fr_pre", 32'(out_data), 32'h5555);
    flush = 1'b1;
    reset = 1'b0;
    cyc();
    flush = 1'b0;
    reset = 1'b1;
    chk("fr_data", 32'(out_data), 32'd0);
    chk("fr_ctrl", 32'(out_ctrl), 32'd0);
    chk("fr_level", 32'(level), 32'd0);
    chk("fr_cnt", 32'(stall_cnt), 32'd0);
    chk("fr_cnt4", 32'(s_stall_cnt), 32'd0);

    // saturation
    out_ready = 1'b0;
    drive(1'b1, 16'h6666, 8'h01);
    cyc();
    drive(1'b1, 16'h7777, 8'h02);
    cyc();
    drive(1'b1, 16'h8888, 8'h03);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 14) chk("sat_14", 32'(s_stall_cnt), 32'd14);
      if (i == 15) chk("sat_15", 32'(s_stall_cnt), 32'hF);
    end
    chk("sat_hold", 32'(s_stall_cnt), 32'hF);
    chk("sat_wide", 32'(stall_cnt), 32'd20);
    drive(1'b0, 16'h0, 8'h0);
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("end_level", 32'(level), 32'd0);
    chk("end_sb", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
